reg_writeback_buffer: RTL and testbench

- Writer-side companion to the triple-ported register file.
- Collects register writebacks from two producers, the ALU stage and the load/memory stage, into a small in-order FIFO.
- Drains at most one entry per cycle onto the register file's single write port.
- Offers forwarding lookups so the two read ports see pending writes that have not yet reached the file.

---
 rtl/reg_writeback_buffer_pkg.sv | 11 +
 rtl/reg_writeback_buffer_fwd_match.sv | 21 ++
 rtl/reg_writeback_buffer.sv | 96 +++++++++
 tb/tb_reg_writeback_buffer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_buffer_pkg.sv
// reg_writeback_buffer_pkg: shared widths, zero-register address and writeback entry record
package reg_writeback_buffer_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam logic [DEF_ADDR_WIDTH-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic                      valid;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_buffer_fwd_match.sv
// wb_fwd_match: youngest-first lookup over an oldest-first entry array
module wb_fwd_match
  import reg_writeback_buffer_pkg::*;
#(
  parameter int N = 5
) (
  input  wb_entry_t                 i_entries [N],
  input  logic [DEF_ADDR_WIDTH-1:0] i_addr,
  output logic                      o_hit,
  output logic [DEF_DATA_WIDTH-1:0] o_data
);
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = 0; i < N; i++)
      if (i_entries[i].valid && i_entries[i].addr == i_addr && i_addr != REG_ZERO) begin
        o_hit  = 1'b1;
        o_data = i_entries[i].data;
      end
  end
endmodule

// File: rtl/reg_writeback_buffer.sv
// reg_writeback_buffer: merges mem/ALU writebacks into an in-order FIFO draining to one
// register-file write port, with forwarding of not-yet-committed writes
module reg_writeback_buffer
  import reg_writeback_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iMemValid,
  input  logic [ADDR_WIDTH-1:0]   iMemAddr,
  input  logic [DATA_WIDTH-1:0]   iMemData,
  output logic                    oMemReady,
  input  logic                    iAluValid,
  input  logic [ADDR_WIDTH-1:0]   iAluAddr,
  input  logic [DATA_WIDTH-1:0]   iAluData,
  output logic                    oAluReady,
  input  logic                    iDrainEn,
  output logic [ADDR_WIDTH-1:0]   oAddrWrite,
  output logic [DATA_WIDTH-1:0]   oDataWrite,
  output logic                    oEnWrite,
  input  logic [ADDR_WIDTH-1:0]   iAddrRead0,
  input  logic [ADDR_WIDTH-1:0]   iAddrRead1,
  output logic                    oFwdHit0,
  output logic [DATA_WIDTH-1:0]   oFwdData0,
  output logic                    oFwdHit1,
  output logic [DATA_WIDTH-1:0]   oFwdData1,
  output logic [$clog2(DEPTH):0]  oCount
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(DEPTH - 1);
  wb_entry_t       r_fifo [DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  logic            r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic            w_mem_nz, w_mem_push, w_alu_push, w_pop;
  logic [PW-1:0]   w_alu_slot;
  wb_entry_t       w_order [DEPTH+1];
  assign w_mem_nz   = iMemValid && iMemAddr != REG_ZERO;
  assign oMemReady  = r_count < FULL;
  assign oAluReady  = w_mem_nz ? r_count < AFULL : r_count < FULL;
  assign w_mem_push = w_mem_nz && oMemReady;
  assign w_alu_push = iAluValid && oAluReady && iAluAddr != REG_ZERO;
  assign w_pop      = r_count != '0 && iDrainEn;
  assign w_alu_slot = r_tail + PW'(w_mem_push);
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      for (int i = 0; i < DEPTH; i++) r_fifo[i].valid <= 1'b0;
    end else begin
      if (w_mem_push) r_fifo[r_tail] <= {1'b1, iMemAddr, iMemData};
      if (w_alu_push) r_fifo[w_alu_slot] <= {1'b1, iAluAddr, iAluData};
      if (w_pop) begin
        r_fifo[r_head].valid <= 1'b0;
        r_addr <= r_fifo[r_head].addr;
        r_data <= r_fifo[r_head].data;
      end
      r_en    <= w_pop;
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_mem_push) + PW'(w_alu_push);
      r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
    end
  end
  // oldest first: the output register, then FIFO entries from head
  always_comb begin
    w_order[0] = {r_en, r_addr, r_data};
    for (int k = 0; k < DEPTH; k++) w_order[k+1] = r_fifo[r_head + PW'(k)];
  end
  wb_fwd_match #(.N(DEPTH + 1)) u_fwd0 (
    .i_entries (w_order),
    .i_addr    (iAddrRead0),
    .o_hit     (oFwdHit0),
    .o_data    (oFwdData0)
  );
  wb_fwd_match #(.N(DEPTH + 1)) u_fwd1 (
    .i_entries (w_order),
    .i_addr    (iAddrRead1),
    .o_hit     (oFwdHit1),
    .o_data    (oFwdData1)
  );
  assign oEnWrite   = r_en;
  assign oAddrWrite = r_addr;
  assign oDataWrite = r_data;
  assign oCount     = r_count;
endmodule

// File: tb/tb_reg_writeback_buffer.sv
// tb_reg_writeback_buffer: directed vectors with hand-computed expectations
module tb_reg_writeback_buffer;
  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iMemValid = 1'b0, iAluValid = 1'b0, iDrainEn = 1'b0;
  logic [4:0]  iMemAddr = '0, iAluAddr = '0, iAddrRead0 = '0, iAddrRead1 = '0;
  logic [31:0] iMemData = '0, iAluData = '0;
  logic        oMemReady, oAluReady, oEnWrite, oFwdHit0, oFwdHit1;
  logic [4:0]  oAddrWrite;
  logic [31:0] oDataWrite, oFwdData0, oFwdData1;
  logic [2:0]  oCount;
  int n_vec = 0;
  int n_err = 0;
  reg_writeback_buffer dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iMemValid(iMemValid), .iMemAddr(iMemAddr), .iMemData(iMemData), .oMemReady(oMemReady),
    .iAluValid(iAluValid), .iAluAddr(iAluAddr), .iAluData(iAluData), .oAluReady(oAluReady),
    .iDrainEn(iDrainEn), .oAddrWrite(oAddrWrite), .oDataWrite(oDataWrite), .oEnWrite(oEnWrite),
    .iAddrRead0(iAddrRead0), .iAddrRead1(iAddrRead1),
    .oFwdHit0(oFwdHit0), .oFwdData0(oFwdData0), .oFwdHit1(oFwdHit1), .oFwdData1(oFwdData1),
    .oCount(oCount)
  );
  always #5 iClk = ~iClk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge iClk);
    #1;
  endtask
  task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    iAluValid = v; iAluAddr = a; iAluData = d;
  endtask
  task automatic mem(input logic v, input logic [4:0] a, input logic [31:0] d);
    iMemValid = v; iMemAddr = a; iMemData = d;
  endtask
  initial begin
    tick; tick;
    check("rst_count", oCount, 0);
    check("rst_en", oEnWrite, 0);
    check("rst_addr", oAddrWrite, 0);
    check("rst_data", oDataWrite, 0);
    check("rst_memrdy", oMemReady, 1);
    check("rst_alurdy", oAluReady, 1);
    iAddrRead0 = 5; iAddrRead1 = 3; #1;
    check("rst_hits", {oFwdHit0, oFwdHit1}, 0);
    iRst_n = 1'b1;
    // single write
    iDrainEn = 1'b1;
    alu(1, 5, 32'hDEADBEEF); #1;
    check("single_rdy", oAluReady, 1);
    tick; alu(0, 0, 0); #1;
    check("single_cnt1", oCount, 1);
    check("single_en0", oEnWrite, 0);
    iAddrRead1 = 5;
    tick;
    check("single_en", oEnWrite, 1);
    check("single_addr", oAddrWrite, 5);
    check("single_data", oDataWrite, 32'hDEADBEEF);
    check("single_cnt0", oCount, 0);
    check("single_fwd_out", {oFwdHit1, oFwdData1}, {1'b1, 32'hDEADBEEF});
    tick;
    check("single_idle_en", oEnWrite, 0);
    check("single_idle_cnt", oCount, 0);
    check("single_idle_hit", {oFwdHit1, oFwdData1}, 0);
    // dual enqueue ordering
    iDrainEn = 1'b0;
    mem(1, 3, 32'h11); alu(1, 3, 32'h22); #1;
    check("dual_rdy", {oMemReady, oAluReady}, 2'b11);
    tick; mem(0, 0, 0); alu(0, 0, 0); iAddrRead0 = 3; #1;
    check("dual_cnt", oCount, 2);
    check("dual_fwd", {oFwdHit0, oFwdData0}, {1'b1, 32'h22});
    check("dual_hold_en", oEnWrite, 0);
    iDrainEn = 1'b1;
    tick;
    check("dual_w1", {oEnWrite, oAddrWrite, oDataWrite}, {1'b1, 5'd3, 32'h11});
    check("dual_w1_fwd", oFwdData0, 32'h22);
    check("dual_w1_cnt", oCount, 1);
    tick;
    check("dual_w2", {oEnWrite, oAddrWrite, oDataWrite}, {1'b1, 5'd3, 32'h22});
    check("dual_w2_cnt", oCount, 0);
    tick;
    check("dual_done", oEnWrite, 0);
    // full / backpressure
    iDrainEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu(1, 5'(10 + i), 32'(100 + i));
      tick;
    end
    mem(1, 8, 32'h88); alu(1, 13, 32'h99); #1;
    check("cnt3", oCount, 3);
    check("cnt3_memrdy", oMemReady, 1);
    check("cnt3_alurdy", oAluReady, 0);
    tick; mem(0, 0, 0); #1;
    check("full_cnt", oCount, 4);
    check("full_rdy", {oMemReady, oAluReady}, 2'b00);
    tick;
    check("full_hold_cnt", oCount, 4);
    iAddrRead0 = 8; #1;
    check("full_fwd", {oFwdHit0, oFwdData0}, {1'b1, 32'h88});
    alu(0, 0, 0);
    iDrainEn = 1'b1;
    tick;
    check("full_d0", {oEnWrite, oAddrWrite, oDataWrite}, {1'b1, 5'd10, 32'd100});
    tick;
    check("full_d1", {oEnWrite, oAddrWrite, oDataWrite}, {1'b1, 5'd11, 32'd101});
    tick;
    check("full_d2", {oEnWrite, oAddrWrite, oDataWrite}, {1'b1, 5'd12, 32'd102});
    tick;
    check("full_d3", {oEnWrite, oAddrWrite, oDataWrite}, {1'b1, 5'd8, 32'h88});
    check("full_d3_cnt", oCount, 0);
    tick;
    check("full_empty_en", oEnWrite, 0);
    // zero register
    iDrainEn = 1'b0;
    mem(1, 0, 32'hFFFFFFFF); #1;
    check("zero_rdy", oMemReady, 1);
    tick; mem(0, 0, 0); iAddrRead1 = 0; #1;
    check("zero_cnt", oCount, 0);
    check("zero_fwd", {oFwdHit1, oFwdData1}, 0);
    iDrainEn = 1'b1;
    tick;
    check("zero_no_write", oEnWrite, 0);
    // forwarding from output register
    alu(1, 7, 32'h55);
    tick; alu(0, 0, 0); iAddrRead1 = 7; #1;
    check("out_pending_fwd", {oFwdHit1, oFwdData1}, {1'b1, 32'h55});
    tick;
    check("out_en", {oEnWrite, oAddrWrite}, {1'b1, 5'd7});
    check("out_fwd", {oFwdHit1, oFwdData1}, {1'b1, 32'h55});
    tick;
    check("out_gone", {oFwdHit1, oFwdData1}, 0);
    // reset mid-operation
    iDrainEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu(1, 5'(20 + i), 32'(200 + i));
      tick;
    end
    alu(0, 0, 0); iAddrRead0 = 21; #1;
    check("mid_cnt", oCount, 3);
    check("mid_fwd", {oFwdHit0, oFwdData0}, {1'b1, 32'd201});
    iRst_n = 1'b0;
    tick;
    iRst_n = 1'b1; #1;
    check("mid_rst_cnt", oCount, 0);
    check("mid_rst_en", oEnWrite, 0);
    check("mid_rst_hit", {oFwdHit0, oFwdHit1}, 0);
    iDrainEn = 1'b1;
    tick;
    check("mid_no_wr1", oEnWrite, 0);
    tick;
    check("mid_no_wr2", {oEnWrite, oCount}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
